// File: rtl/wm_pkg.sv
// rtl/wm_pkg.sv - state/operation codes and fill-time helper for the wash cycle controller
package wm_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FILL    = 4'd1,
        ST_HEAT    = 4'd2,
        ST_PREWASH = 4'd3,
        ST_WASH    = 4'd4,
        ST_RINSE   = 4'd5,
        ST_SPIN    = 4'd6,
        ST_PAUSE   = 4'd7,
        ST_FAULT   = 4'd8,
        ST_DONE    = 4'd9
    } wm_state_e;

    typedef enum logic [1:0] {
        OP_FULL       = 2'd0,
        OP_WASH_SPIN  = 2'd1,
        OP_RINSE_SPIN = 2'd2,
        OP_SPIN       = 2'd3
    } wm_op_e;

    localparam int FILL_BASE_DEF = 4;
    localparam int FILL_STEP_DEF = 2;

    function automatic int fill_dur(input logic [1:0] weight,
                                    input int base = FILL_BASE_DEF,
                                    input int step = FILL_STEP_DEF);
        return base + int'(weight) * step;
    endfunction

endpackage

// File: rtl/wm_phase_timer.sv
// rtl/wm_phase_timer.sv - phase timer: counts up from 0, freezes on hold or at terminal count
module wm_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic             hold,
    input  logic [CNT_W-1:0] tc_val,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    // Stopping at tc keeps the counter from wrapping if a phase is held at its end.
    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            count <= '0;
        end else if (!hold && !tc) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc = (count == tc_val);

endmodule

// File: rtl/wash_cycle_controller.sv
// rtl/wash_cycle_controller.sv - washing-machine phase sequencer with pause, fault and rinse repeat
// Optional PREWASH phase (op0 only) enabled by defining PREWASH_EN.
module wash_cycle_controller
    import wm_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int FILL_BASE = 4,
    parameter int FILL_STEP = 2,
    parameter int HEAT_T    = 6,
    parameter int WASH_T    = 10,
    parameter int RINSE_T   = 5,
    parameter int SPIN_T    = 8,
    parameter int RINSE_W   = 2
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic               Close_Door,
    input  logic               Open_Door,
    input  logic               Clothes_in,
    input  logic               Start,
    input  logic [1:0]         Weight,
    input  logic [1:0]         Operation,
    input  logic [RINSE_W-1:0] Rinse_Cnt,
    input  logic               Pause,
    input  logic               Stop,
    output logic [3:0]         State,
    output logic               Phase_Done,
    output logic               Finish,
    output logic               Failure,
    output logic               Door_Lock,
    output logic               Paused,
    output logic [RINSE_W-1:0] Rinse_Left
);

`ifdef PREWASH_EN
    localparam bit PREWASH_ON = 1'b1;
`else
    localparam bit PREWASH_ON = 1'b0;
`endif
    localparam int PREWASH_T = (WASH_T / 2 < 1) ? 1 : WASH_T / 2;
    localparam int FILL_MAX  = FILL_BASE + 3 * FILL_STEP;

    if (FILL_BASE < 1 || FILL_STEP < 0 || HEAT_T < 1 || WASH_T < 1 || RINSE_T < 1 || SPIN_T < 1 ||
        FILL_MAX > 2**CNT_W || HEAT_T > 2**CNT_W || WASH_T > 2**CNT_W ||
        RINSE_T > 2**CNT_W || SPIN_T > 2**CNT_W) begin : g_bad_duration
        $error("wash_cycle_controller: phase duration is zero or exceeds the timer range");
    end

    wm_state_e          state, nxt, saved, after;
    wm_op_e             op_q;
    logic [1:0]         weight_q;
    logic [RINSE_W-1:0] rinse_left;
    logic [CNT_W-1:0]   tc_val;
    logic               tc, complete, t_clr, t_hold;

    function automatic logic run_phase(input wm_state_e s);
        return (s inside {ST_FILL, ST_HEAT, ST_WASH, ST_RINSE, ST_SPIN}) ||
               (PREWASH_ON && s == ST_PREWASH);
    endfunction

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state      <= ST_IDLE;
            saved      <= ST_IDLE;
            op_q       <= OP_FULL;
            weight_q   <= '0;
            rinse_left <= '0;
        end else begin
            state <= nxt;
            if (nxt == ST_PAUSE && state != ST_PAUSE) saved <= state;
            if (Stop) begin
                rinse_left <= '0;
            end else if (state == ST_IDLE && nxt != ST_IDLE) begin
                op_q     <= wm_op_e'(Operation);
                weight_q <= Weight;
                if (Operation == OP_FULL || Operation == OP_RINSE_SPIN)
                    rinse_left <= (Rinse_Cnt == '0) ? RINSE_W'(1) : Rinse_Cnt;
                else
                    rinse_left <= '0;
            end else if (complete && state == ST_RINSE) begin
                rinse_left <= rinse_left - RINSE_W'(1);
            end
        end
    end

    always_comb begin
        after = ST_DONE;
        case (state)
            ST_FILL:    after = (op_q == OP_RINSE_SPIN) ? ST_RINSE : ST_HEAT;
            ST_HEAT:    after = (PREWASH_ON && op_q == OP_FULL) ? ST_PREWASH : ST_WASH;
            ST_PREWASH: after = ST_WASH;
            ST_WASH:    after = (op_q == OP_FULL) ? ST_RINSE : ST_SPIN;
            ST_RINSE:   after = (rinse_left > RINSE_W'(1)) ? ST_RINSE : ST_SPIN;
            default:    after = ST_DONE;
        endcase
    end

    always_comb begin
        nxt      = state;
        complete = 1'b0;
        if (Stop) begin
            nxt = ST_IDLE;
        end else if (run_phase(state)) begin
            if (Open_Door)  nxt = ST_FAULT;
            else if (Pause) nxt = ST_PAUSE;
            else if (tc) begin
                complete = 1'b1;
                nxt      = after;
            end
        end else begin
            case (state)
                ST_IDLE:
                    if (Start && Close_Door && Clothes_in && !Open_Door)
                        nxt = (Operation == OP_SPIN) ? ST_SPIN : ST_FILL;
                ST_PAUSE:
                    if (Open_Door)   nxt = ST_FAULT;
                    else if (!Pause) nxt = saved;
                ST_FAULT: nxt = ST_FAULT;
                ST_DONE:  nxt = ST_IDLE;
                default:  nxt = ST_FAULT;
            endcase
        end
    end

    // Timer is frozen on the way into and out of PAUSE so a resumed phase continues where it left off.
    always_comb begin
        t_clr  = 1'b0;
        t_hold = 1'b0;
        if (nxt == ST_PAUSE || (state == ST_PAUSE && run_phase(nxt)))
            t_hold = 1'b1;
        else if (!run_phase(nxt) || nxt != state || complete)
            t_clr = 1'b1;
    end

    always_comb begin
        tc_val = '0;
        case (state)
            ST_FILL:    tc_val = CNT_W'(fill_dur(weight_q, FILL_BASE, FILL_STEP) - 1);
            ST_HEAT:    tc_val = CNT_W'(HEAT_T - 1);
            ST_PREWASH: tc_val = CNT_W'(PREWASH_T - 1);
            ST_WASH:    tc_val = CNT_W'(WASH_T - 1);
            ST_RINSE:   tc_val = CNT_W'(RINSE_T - 1);
            ST_SPIN:    tc_val = CNT_W'(SPIN_T - 1);
            default:    tc_val = '0;
        endcase
    end

    wm_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (CLK),
        .resetn (RST_n),
        .clr    (t_clr),
        .hold   (t_hold),
        .tc_val (tc_val),
        .tc     (tc)
    );

    assign State      = state;
    assign Phase_Done = run_phase(state) && tc;
    assign Finish     = (state == ST_DONE);
    assign Failure    = (state == ST_FAULT);
    assign Door_Lock  = !(state inside {ST_IDLE, ST_FAULT, ST_DONE});
    assign Paused     = (state == ST_PAUSE);
    assign Rinse_Left = rinse_left;

endmodule
